seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial bit-sequence detector, the generalised successor to our fixed-pattern Mealy detectors. The pattern, pattern length and counter width are parameters, and overlap versus non-overlap is selected at run time. A valid qualifier allows gapped input, and a saturating match counter is included. It sits directly on a single-bit serial stream and produces a registered one-cycle match pulse for downstream control logic.

## Interface
- `LEN`, 4 — pattern length in bits; legal range 2..16.
- `PATTERN`, 4'b1001 — `LEN`-bit pattern; `PATTERN[LEN-1]` is the first bit received.
- `CNT_W`, 8 — match counter width; legal range 1..32.

Ports:
- `clk` in 1 — single clock; all logic is on the rising edge.
- `reset` in 1 — synchronous, active-high reset.
- `din_valid` in 1 — `din` is sampled only when this is 1.
- `din` in 1 — serial data bit.
- `overlap_en` in 1 — 1 selects overlapping detection, 0 selects non-overlapping; sampled per valid beat.
- `clr_cnt` in 1 — synchronous clear of `match_cnt`.
- `dout` out 1 — registered match pulse.
- `match_cnt` out `CNT_W` — saturating count of matches.
- `prefix_len` out `$clog2(LEN)` — current matched-prefix length, i.e. the state, for debug.

## Operation
- State is the matched-prefix length `k`, ranging 0..LEN-1.
- On a valid beat, the candidate is `c = delta(k, din)`:
  - If `din` equals the next pattern bit `PATTERN[LEN-1-k]`, then `c = k+1`.
  - Otherwise, fall back along the failure function (KMP) to the longest proper prefix of the pattern that is a suffix of the received history plus `din`.
- If `c < LEN`: the state becomes `c` and `dout` is set to 0.
- If `c == LEN`, a match occurs and `dout` is set to 1:
  - When `overlap_en=1`, the next state is `fail(LEN)`, the longest proper prefix that is also a suffix of `PATTERN`.
  - When `overlap_en=0`, the next state is 0.
- When `din_valid=0`: the state holds, `dout` is set to 0, and `din` is ignored.
- `match_cnt`:
  - Increments by 1 on every match.
  - Saturates at 2^CNT_W−1 and never wraps.
  - If `clr_cnt` and a match occur in the same cycle, the clear wins and `match_cnt` becomes 0.
- Failure mismatch is mandatory. A mismatch must never fall back to an incorrect partial state. For pattern 1001 after receiving "100" then 0, the state is 0, not 2.
- Reset values: state 0, `dout` 0, `match_cnt` 0, `prefix_len` 0.

## Timing
- Latency is 1 cycle. `dout` is high in the cycle after the edge that samples the final pattern bit.
- `dout` is high for exactly 1 cycle per match.
- Back-to-back matches on consecutive valid beats give consecutive `dout` pulses. This is only possible with overlap enabled and `fail(LEN) = LEN-1`, e.g. pattern 11.
- `match_cnt` updates on the same edge as `dout`.
- `overlap_en` takes effect at the edge of the beat being sampled; no pipelining.
- `reset` asserted mid-sequence:
  - Partial progress is discarded.
  - `dout` is 0 in the following cycle, even if the reset cycle carried a completing bit.
  - `match_cnt` is cleared.
- `clr_cnt` does not affect detection state.

## Structure
- The package `seq_det_pkg` holds:
  - the constant function `seq_fail(pattern, len, k)`, which returns the failure value;
  - the constant function `seq_next(pattern, len, k, bit)`, which returns the next state.
- The transition table `NEXT[k][bit]` and `FAIL_LEN` are built at elaboration by a generate/initial loop over these functions. There is no run-time failure computation.
- The sub-module `seq_match_counter` holds the saturating counter with clear priority. It is parametrised by `CNT_W`.
- The top level holds only the state register, the table lookup and the `dout` register.

## Test plan
All scenarios use `LEN=4`, `PATTERN=4'b1001` unless stated otherwise, with `din_valid` held at 1 unless stated otherwise.

- **Overlap on:** stream 1001001 -> `dout` pulses after bit 4 and after bit 7; `match_cnt=2`.
- **Overlap off:** same stream 1001001 -> one pulse after bit 4; `match_cnt=1`.
- **Failure fallback:** stream 10001001 -> no pulse after bit 4 (`prefix_len` is 0 after bit 4); one pulse after bit 8.
- **Gapped input:** bits 1,0 then `din_valid=0` for 3 cycles with `din` toggling, then 0,1 -> one pulse; `prefix_len` holds 2 during the gap.
- **Reset mid-sequence:** 1,0,0 then `reset` for 1 cycle, then 1 -> no pulse; `match_cnt=0`.
- **Counter saturation and clear** (`CNT_W=2`, pattern 11, overlap on):
  - Stream of six 1s -> five matches; `match_cnt` saturates at 3.
  - `clr_cnt` coincident with a further match -> `match_cnt=0` while `dout=1`.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised sequence detector.
// Both functions are evaluated only at elaboration to build the transition table.
// Bit i of the pattern string (i = 0 is the first bit received) is pattern[len-1-i].
package seq_det_pkg;

    localparam int SEQ_MAX_LEN = 16;

    // Length of the longest proper prefix of the first k pattern bits
    // that is also a suffix of those same k bits.
    function automatic int seq_fail(input logic [SEQ_MAX_LEN-1:0] pattern,
                                    input int len, input int k);
        int  res;
        logic found;
        logic ok;
        res   = 0;
        found = 1'b0;
        for (int l = k - 1; l > 0; l--) begin
            ok = 1'b1;
            for (int j = 0; j < l; j++) begin
                if (pattern[len-1-j] != pattern[len-1-(k-l+j)]) ok = 1'b0;
            end
            if (ok && !found) begin
                res   = l;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Next matched-prefix length from state k on input bit b. The result can
    // be len, which signals a full match. A mismatch takes the longest prefix
    // of the pattern that is a suffix of (first k pattern bits) followed by b.
    function automatic int seq_next(input logic [SEQ_MAX_LEN-1:0] pattern,
                                    input int len, input int k, input int b);
        int   res;
        logic found;
        logic ok;
        res   = 0;
        found = 1'b0;
        if (int'(pattern[len-1-k]) == b) begin
            res   = k + 1;
            found = 1'b1;
        end
        for (int c = k; c > 0; c--) begin
            ok = (int'(pattern[len-c]) == b);
            for (int j = 0; j < c - 1; j++) begin
                if (pattern[len-1-j] != pattern[len-1-(k-c+1+j)]) ok = 1'b0;
            end
            if (ok && !found) begin
                res   = c;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter; a clear request beats a simultaneous increment.
module seq_match_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count matches, hold at all-ones, clear on reset or explicit clear
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector with a KMP-style transition table.
// State is the matched-prefix length; the table is fully constant.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1001,
    parameter int             CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    din_valid,
    input  logic                    din,
    input  logic                    overlap_en,
    input  logic                    clr_cnt,
    output logic                    dout,
    output logic [CNT_W-1:0]        match_cnt,
    output logic [$clog2(LEN)-1:0]  prefix_len
);

    localparam int SW  = $clog2(LEN);       // state width, states 0..LEN-1
    localparam int CW  = $clog2(LEN + 1);   // candidate width, 0..LEN
    localparam int NST = 2 ** SW;           // table rows, unreachable rows are 0

    localparam logic [SEQ_MAX_LEN-1:0] PAT16    = SEQ_MAX_LEN'(PATTERN);
    localparam logic [SW-1:0]          FAIL_LEN = SW'(seq_fail(PAT16, LEN, LEN));

    logic [NST-1:0][1:0][CW-1:0] w_next_tbl;
    logic [CW-1:0]               w_cand;
    logic                        w_match;
    logic [SW-1:0]               r_state;
    logic                        r_dout;

    // Elaboration-time transition table NEXT[k][bit]
    for (genvar gk = 0; gk < NST; gk++) begin : g_k
        for (genvar gb = 0; gb < 2; gb++) begin : g_b
            localparam int NX = (gk < LEN) ? seq_next(PAT16, LEN, gk, gb) : 0;
            assign w_next_tbl[gk][gb] = CW'(NX);
        end
    end

    assign w_cand  = w_next_tbl[r_state][din];
    assign w_match = din_valid && (w_cand == CW'(LEN));

    // Advance the matched prefix on valid beats and register the match pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= '0;
            r_dout  <= 1'b0;
        end else if (din_valid) begin
            if (w_match) begin
                r_state <= overlap_en ? FAIL_LEN : '0;
                r_dout  <= 1'b1;
            end else begin
                r_state <= w_cand[SW-1:0];
                r_dout  <= 1'b0;
            end
        end else begin
            r_dout <= 1'b0;
        end
    end

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_match),
        .i_clr (clr_cnt),
        .o_cnt (match_cnt)
    );

    assign dout       = r_dout;
    assign prefix_len = r_state;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: two detector configurations share one random/directed stream.
// The reference model keeps raw received history and searches it for the pattern.
module tb_seq_detector_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, din_valid = 1'b0, din = 1'b0, overlap_en = 1'b0, clr_cnt = 1'b0;

    logic       a_dout;
    logic [7:0] a_cnt;
    logic [1:0] a_pref;
    logic       b_dout;
    logic [1:0] b_cnt;
    logic       b_pref;

    seq_detector_param #(.LEN(4), .PATTERN(4'b1001), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
        .overlap_en(overlap_en), .clr_cnt(clr_cnt),
        .dout(a_dout), .match_cnt(a_cnt), .prefix_len(a_pref));

    seq_detector_param #(.LEN(2), .PATTERN(2'b11), .CNT_W(2)) u_b (
        .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
        .overlap_en(overlap_en), .clr_cnt(clr_cnt),
        .dout(b_dout), .match_cnt(b_cnt), .prefix_len(b_pref));

    typedef struct {
        bit ad; int ac; int ap;
        bit bd; int bc; int bp;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    bit [31:0] ha = '0, hb = '0;
    int hla = 0, hlb = 0, ca = 0, cb = 0;
    int errors = 0, checks = 0;

    // Longest l <= maxl such that the newest l history bits equal the first l pattern bits
    function automatic int longest(bit [31:0] h, int hl, bit [15:0] pat, int len, int maxl);
        int best = 0;
        for (int l = 1; l <= maxl; l++) begin
            bit ok = (l <= hl);
            for (int j = 0; j < l; j++) if (h[l-1-j] != pat[len-1-j]) ok = 1'b0;
            if (ok) best = l;
        end
        return best;
    endfunction

    task automatic upd(input bit [15:0] pat, input int len, input int cmax,
                       inout bit [31:0] h, inout int hl, inout int c,
                       output bit d, output int p);
        bit m = 1'b0;
        if (reset) begin
            h = '0; hl = 0; c = 0;
        end else begin
            if (din_valid) begin
                h = {h[30:0], din};
                if (hl < 32) hl++;
                m = (longest(h, hl, pat, len, len) == len);
                if (m && !overlap_en) hl = 0;
            end
            if (clr_cnt) c = 0;
            else if (m && c < cmax) c++;
        end
        d = m;
        p = longest(h, hl, pat, len, len - 1);
    endtask

    task automatic step(input bit r, input bit v, input bit d, input bit ov, input bit clr);
        exp_t x;
        @(negedge clk);
        reset = r; din_valid = v; din = d; overlap_en = ov; clr_cnt = clr;
        upd(16'b1001, 4, 255, ha, hla, ca, x.ad, x.ap);
        x.ac = ca;
        upd(16'b11, 2, 3, hb, hlb, cb, x.bd, x.bp);
        x.bc = cb;
        sb.push_back(x);
    endtask

    task automatic bits(input string s, input bit ov);
        for (int i = 0; i < s.len(); i++) step(1'b0, 1'b1, s[i] == "1", ov, 1'b0);
    endtask

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", n, act, exp, $time);
        end
    endtask

    // Monitor: outputs are registered, so compare just after each edge
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("a_dout", int'(a_dout), int'(e.ad));
            chk("a_match_cnt", int'(a_cnt), e.ac);
            chk("a_prefix_len", int'(a_pref), e.ap);
            chk("b_dout", int'(b_dout), int'(e.bd));
            chk("b_match_cnt", int'(b_cnt), e.bc);
            chk("b_prefix_len", int'(b_pref), e.bp);
        end
    end

    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // overlapping detection
        bits("1001001", 1'b1);
        step(1, 0, 0, 0, 0);
        // non-overlapping detection
        bits("1001001", 1'b0);
        step(1, 0, 0, 0, 0);
        // mismatch fallback to zero
        bits("10001001", 1'b1);
        step(1, 0, 0, 0, 0);
        // gapped input with din toggling during the gap
        bits("10", 1'b1);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        bits("01", 1'b1);
        // reset carrying a completing bit
        step(1, 0, 0, 0, 0);
        bits("100", 1'b1);
        step(1, 1, 1, 1, 0);
        bits("1", 1'b1);
        // saturation on the 2-bit pattern, then clear against a match
        step(1, 0, 0, 0, 0);
        bits("111111", 1'b1);
        step(0, 1, 1, 1, 1);
        bits("11", 1'b1);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 31) == 0));
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
